// File: rtl/aurora_pkg.sv
// Shared definitions for the memory-access stage.
// Contents: FSM state encoding, default datapath widths and the MEM/WB
// bubble value driven whenever no instruction completes.
package aurora_pkg;

    localparam int MEM_DATA_W  = 64;
    localparam int MEM_ADDR_W  = 64;
    localparam int MEM_RADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                   en;
        logic [MEM_RADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0]  data;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '{en: 1'b0, addr: 5'd0, data: 64'd0};

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wb_en/addr/data       write-back mux output, destination and enable
//   o_wb_en/addr/data       registered MEM/WB bundle (all zero in reset)
module mem_wb_reg #(
    parameter int DATA_W  = 64,
    parameter int RADDR_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_en,
    input  logic [RADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0]  i_wb_data,
    output logic               o_wb_en,
    output logic [RADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0]  o_wb_data
);

    logic               r_wb_en;
    logic [RADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0]  r_wb_data;

    // Capture the write-back bundle every cycle (bubbles included).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en   <= i_wb_en;
            r_wb_addr <= i_wb_addr;
            r_wb_data <= i_wb_data;
        end
    end

    assign o_wb_en   = r_wb_en;
    assign o_wb_addr = r_wb_addr;
    assign o_wb_data = r_wb_data;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: aligned 64-bit loads/stores over a
// valid/ready data-memory port, upstream stall while an access is
// outstanding, registered MEM/WB output.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   reg_write_en_i .. reg_write_addr_i   EX/MEM bundle
//   stall_o                        freeze EX/MEM while not IDLE
//   dmem_req_* / dmem_rsp_*        data-memory request/response port
//   reg_write_en_o/addr_o, wb_data_o  MEM/WB bundle
//   misaligned_o                   one-cycle pulse on a dropped access
module mem_stage
    import aurora_pkg::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int RADDR_W = MEM_RADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               reg_write_en_i,
    input  logic               mem_write_en_i,
    input  logic               mem_read_en_i,
    input  logic               mem_to_reg_i,
    input  logic [DATA_W-1:0]  alu_i,
    input  logic [DATA_W-1:0]  reg_data2_i,
    input  logic [RADDR_W-1:0] reg_write_addr_i,
    output logic               stall_o,
    output logic               dmem_req_valid_o,
    input  logic               dmem_req_ready_i,
    output logic               dmem_req_we_o,
    output logic [ADDR_W-1:0]  dmem_req_addr_o,
    output logic [DATA_W-1:0]  dmem_req_wdata_o,
    input  logic               dmem_rsp_valid_i,
    input  logic [DATA_W-1:0]  dmem_rsp_rdata_i,
    output logic               reg_write_en_o,
    output logic [RADDR_W-1:0] reg_write_addr_o,
    output logic [DATA_W-1:0]  wb_data_o,
    output logic               misaligned_o
);

    mem_state_e         r_state;
    mem_state_e         w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_we;
    logic               r_reg_we;
    logic [RADDR_W-1:0] r_reg_waddr;
    logic               r_mem_to_reg;
    logic               r_misaligned;
    logic               w_accept;
    logic               w_misaligned;
    logic               w_wb_en;
    logic [RADDR_W-1:0] w_wb_addr;
    logic [DATA_W-1:0]  w_wb_data;

    // Next-state and write-back mux; default is a bubble, only a completing
    // instruction overrides it.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_misaligned = 1'b0;
        w_wb_en      = MEM_WB_BUBBLE.en;
        w_wb_addr    = MEM_WB_BUBBLE.addr;
        w_wb_data    = MEM_WB_BUBBLE.data;
        case (r_state)
            IDLE: begin
                if (mem_read_en_i || mem_write_en_i) begin
                    if (alu_i[2:0] != 3'b000) begin
                        w_misaligned = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = REQ;
                    end
                end else begin
                    w_wb_en   = reg_write_en_i;
                    w_wb_addr = reg_write_addr_i;
                    w_wb_data = alu_i;
                end
            end
            REQ: begin
                if (dmem_req_ready_i) begin
                    if (r_we) begin
                        // Stores complete on the handshake; data is the ALU result.
                        w_next_state = IDLE;
                        w_wb_en      = r_reg_we;
                        w_wb_addr    = r_reg_waddr;
                        w_wb_data    = r_addr;
                    end else begin
                        w_next_state = WAIT_RSP;
                    end
                end else begin
                    w_next_state = REQ;
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid_i) begin
                    w_next_state = IDLE;
                    w_wb_en      = r_reg_we;
                    w_wb_addr    = r_reg_waddr;
                    w_wb_data    = r_mem_to_reg ? dmem_rsp_rdata_i : r_addr;
                end else begin
                    w_next_state = WAIT_RSP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register plus request latch; the latch holds addr/wdata/we
    // stable for the whole REQ phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_reg_we     <= 1'b0;
            r_reg_waddr  <= '0;
            r_mem_to_reg <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_misaligned <= w_misaligned;
            if (w_accept) begin
                r_addr       <= alu_i[ADDR_W-1:0];
                r_wdata      <= reg_data2_i;
                // Read wins when both enables are set.
                r_we         <= mem_write_en_i & ~mem_read_en_i;
                r_reg_we     <= reg_write_en_i;
                r_reg_waddr  <= reg_write_addr_i;
                r_mem_to_reg <= mem_to_reg_i & mem_read_en_i;
            end else begin
                r_addr       <= r_addr;
                r_wdata      <= r_wdata;
                r_we         <= r_we;
                r_reg_we     <= r_reg_we;
                r_reg_waddr  <= r_reg_waddr;
                r_mem_to_reg <= r_mem_to_reg;
            end
        end
    end

    assign stall_o          = (r_state != IDLE);
    assign dmem_req_valid_o = (r_state == REQ);
    assign dmem_req_we_o    = r_we;
    assign dmem_req_addr_o  = r_addr;
    assign dmem_req_wdata_o = r_wdata;
    assign misaligned_o     = r_misaligned;

    mem_wb_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_mem_wb_reg (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (w_wb_addr),
        .i_wb_data (w_wb_data),
        .o_wb_en   (reg_write_en_o),
        .o_wb_addr (reg_write_addr_o),
        .o_wb_data (wb_data_o)
    );

endmodule
